// File: rtl/block_mover_if.sv
// Bus bundle for block_mover: scancode/tick inputs from upstream and
// block position/status outputs toward the VGA rectangle compare.
interface block_mover_if;
    logic        mode;
    logic [7:0]  scan_code;
    logic        scan_valid;
    logic        move_tick;
    logic [10:0] i;
    logic [10:0] j;
    logic [3:0]  keys_held;
    logic        at_edge;

    // Drives keyboard/tick stimulus, observes position
    modport master (
        output mode, scan_code, scan_valid, move_tick,
        input  i, j, keys_held, at_edge
    );

    // The block mover itself
    modport slave (
        input  mode, scan_code, scan_valid, move_tick,
        output i, j, keys_held, at_edge
    );
endinterface

// File: rtl/block_mover.sv
// block_mover: PS/2 scancode decoder plus clamped (or wrapping) rectangle
// position stepper. Define BLOCK_MOVER_WRAP_EN to wrap at limits instead of
// clamping; at_edge then never asserts.
module block_mover #(
    parameter logic [10:0] BLOCK_W = 11'd100,
    parameter logic [10:0] BLOCK_H = 11'd100,
    parameter logic [10:0] STEP    = 11'd4
) (
    input  logic         clk,
    input  logic         rst_n,
    block_mover_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} dec_state_e;

    dec_state_e  state_q, state_d;
    logic [3:0]  keys_q, keys_d;
    logic [10:0] i_q, i_d, j_q, j_d;
    logic        edge_q, edge_d;
    logic        recentre;
    logic [10:0] h_max, v_max;
    logic [10:0] i_mv, j_mv;
    logic        clip_h, clip_v;

    assign h_max = bus.mode ? (11'd800 - BLOCK_W) : (11'd640 - BLOCK_W);
    assign v_max = bus.mode ? (11'd600 - BLOCK_H) : (11'd480 - BLOCK_H);

    // keys_held bit order is {up, down, left, right}
    function automatic logic [3:0] plain_key(input logic [7:0] code);
        case (code)
            8'h1D:   return 4'b1000;
            8'h1B:   return 4'b0100;
            8'h1C:   return 4'b0010;
            8'h23:   return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] ext_key(input logic [7:0] code);
        case (code)
            8'h75:   return 4'b1000;
            8'h72:   return 4'b0100;
            8'h6B:   return 4'b0010;
            8'h74:   return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    // One axis step: returns {clipped, new_pos}; inc/dec both set cancel out
    function automatic logic [11:0] step_axis(input logic [10:0] pos, input logic [10:0] lim,
                                              input logic inc, input logic dec);
        logic [11:0] sum;
        sum = {1'b0, pos} + {1'b0, STEP};
        if (inc && !dec) begin
            if (sum > {1'b0, lim}) begin
`ifdef BLOCK_MOVER_WRAP_EN
                return {1'b0, 11'd0};
`else
                return {1'b1, lim};
`endif
            end
            return {1'b0, sum[10:0]};
        end else if (dec && !inc) begin
            if (pos < STEP) begin
`ifdef BLOCK_MOVER_WRAP_EN
                return {1'b0, lim};
`else
                return {1'b1, 11'd0};
`endif
            end
            return {1'b0, pos - STEP};
        end
        return {1'b0, pos};
    endfunction

    // Scancode decoder: prefix tracking and held-key flags
    always_comb begin
        state_d  = state_q;
        keys_d   = keys_q;
        recentre = 1'b0;
        if (bus.scan_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (bus.scan_code == 8'hE0) begin
                        state_d = StExt;
                    end else if (bus.scan_code == 8'hF0) begin
                        state_d = StBrk;
                    end else begin
                        keys_d   = keys_q | plain_key(bus.scan_code);
                        recentre = (bus.scan_code == 8'h29);
                    end
                end
                StExt: begin
                    if (bus.scan_code == 8'hF0) begin
                        state_d = StExtBrk;
                    end else begin
                        keys_d  = keys_q | ext_key(bus.scan_code);
                        state_d = StIdle;
                    end
                end
                StBrk: begin
                    keys_d  = keys_q & ~plain_key(bus.scan_code);
                    state_d = StIdle;
                end
                StExtBrk: begin
                    keys_d  = keys_q & ~ext_key(bus.scan_code);
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Motion, recentre and limit re-clamp; motion sees the pre-edge key flags
    always_comb begin
        {clip_h, i_mv} = step_axis(i_q, h_max, keys_q[0], keys_q[1]);
        {clip_v, j_mv} = step_axis(j_q, v_max, keys_q[2], keys_q[3]);
        i_d    = i_q;
        j_d    = j_q;
        edge_d = edge_q;
        if (recentre) begin
            i_d = h_max >> 1;
            j_d = v_max >> 1;
        end else if (bus.move_tick) begin
            i_d = i_mv;
            j_d = j_mv;
        end
        if (bus.move_tick) begin
            edge_d = clip_h | clip_v;
        end
        // A mode switch can leave the block outside the new frame
        if (i_d > h_max) begin
            i_d = h_max;
        end
        if (j_d > v_max) begin
            j_d = v_max;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            keys_q  <= 4'b0000;
            i_q     <= 11'd0;
            j_q     <= 11'd0;
            edge_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            keys_q  <= keys_d;
            i_q     <= i_d;
            j_q     <= j_d;
            edge_q  <= edge_d;
        end
    end

    assign bus.i         = i_q;
    assign bus.j         = j_q;
    assign bus.keys_held = keys_q;
    assign bus.at_edge   = edge_q;

endmodule

// File: tb/tb_block_mover.sv
// Directed bench for block_mover with a behavioural position model checked
// every cycle, plus literal checkpoints from hand-worked scenarios.
module tb_block_mover;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    block_mover_if bus ();

    block_mover dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [10:0] m_i, m_j;
    logic [3:0]  m_keys;
    logic        m_edge;
    logic        m_ext, m_brk;

    function automatic logic [3:0] key_of(input logic ext, input logic [7:0] c);
        logic [3:0] k;
        k = 4'b0000;
        if (!ext) begin
            if (c == 8'h1D) k = 4'b1000;
            if (c == 8'h1B) k = 4'b0100;
            if (c == 8'h1C) k = 4'b0010;
            if (c == 8'h23) k = 4'b0001;
        end else begin
            if (c == 8'h75) k = 4'b1000;
            if (c == 8'h72) k = 4'b0100;
            if (c == 8'h6B) k = 4'b0010;
            if (c == 8'h74) k = 4'b0001;
        end
        return k;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        int         hmax, vmax, ni, nj, dx, dy;
        logic [3:0] nk;
        logic       ne, nb, rec, clip;
        if (!rst_n) begin
            m_i    <= '0;
            m_j    <= '0;
            m_keys <= '0;
            m_edge <= 1'b0;
            m_ext  <= 1'b0;
            m_brk  <= 1'b0;
        end else begin
            hmax = (bus.mode ? 800 : 640) - 100;
            vmax = (bus.mode ? 600 : 480) - 100;
            nk   = m_keys;
            ne   = m_ext;
            nb   = m_brk;
            rec  = 1'b0;
            if (bus.scan_valid) begin
                if (m_brk) begin
                    nk = nk & ~key_of(m_ext, bus.scan_code);
                    ne = 1'b0;
                    nb = 1'b0;
                end else if (bus.scan_code == 8'hF0) begin
                    nb = 1'b1;
                end else if (bus.scan_code == 8'hE0 && !m_ext) begin
                    ne = 1'b1;
                end else begin
                    nk  = nk | key_of(m_ext, bus.scan_code);
                    rec = !m_ext && bus.scan_code == 8'h29;
                    ne  = 1'b0;
                end
            end
            ni   = int'(m_i);
            nj   = int'(m_j);
            clip = 1'b0;
            dx   = int'(m_keys[0]) - int'(m_keys[1]);
            dy   = int'(m_keys[2]) - int'(m_keys[3]);
            if (bus.move_tick) begin
                ni = ni + 4 * dx;
                nj = nj + 4 * dy;
`ifdef BLOCK_MOVER_WRAP_EN
                if (ni > hmax) ni = 0;
                if (ni < 0)    ni = hmax;
                if (nj > vmax) nj = 0;
                if (nj < 0)    nj = vmax;
`else
                if (dx != 0 && ni > hmax) begin ni = hmax; clip = 1'b1; end
                if (dx != 0 && ni < 0)    begin ni = 0;    clip = 1'b1; end
                if (dy != 0 && nj > vmax) begin nj = vmax; clip = 1'b1; end
                if (dy != 0 && nj < 0)    begin nj = 0;    clip = 1'b1; end
`endif
            end
            if (rec) begin
                ni = int'(m_i) * 0 + hmax / 2;
                nj = vmax / 2;
            end
            if (ni > hmax) ni = hmax;
            if (nj > vmax) nj = vmax;
            m_i    <= 11'(ni);
            m_j    <= 11'(nj);
            m_keys <= nk;
            m_ext  <= ne;
            m_brk  <= nb;
            if (bus.move_tick) m_edge <= clip;
        end
    end

    // Compare DUT to model every cycle out of reset, away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            check("i", 32'(bus.i), 32'(m_i));
            check("j", 32'(bus.j), 32'(m_j));
            check("keys_held", 32'(bus.keys_held), 32'(m_keys));
            check("at_edge", 32'(bus.at_edge), 32'(m_edge));
        end
    end

    // ---------------- stimulus ----------------
    // Each call drives one cycle starting just after a posedge
    task automatic cyc(input logic v, input logic [7:0] c, input logic t);
        bus.scan_valid = v;
        bus.scan_code  = c;
        bus.move_tick  = t;
        @(posedge clk);
        #1;
        bus.scan_valid = 1'b0;
        bus.scan_code  = 8'h00;
        bus.move_tick  = 1'b0;
    endtask

    task automatic send(input logic [7:0] c);
        cyc(1'b1, c, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 8'h00, 1'b1);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst_n          = 1'b1;
        bus.mode       = 1'b0;
        bus.scan_code  = 8'h00;
        bus.scan_valid = 1'b0;
        bus.move_tick  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("reset_i", 32'(bus.i), 32'd0);
        check("reset_keys", 32'(bus.keys_held), 32'd0);
        check("reset_edge", 32'(bus.at_edge), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Asynchronous reset mid-motion at i = 200
        send(8'h23);
        ticks(50);
        check("pre_reset_i", 32'(bus.i), 32'd200);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_i", 32'(bus.i), 32'd0);
        check("async_reset_j", 32'(bus.j), 32'd0);
        check("async_reset_keys", 32'(bus.keys_held), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Plain right make, 10 ticks, then break
        send(8'h23);
        ticks(10);
        check("right10_i", 32'(bus.i), 32'd40);
        check("right10_keys", 32'(bus.keys_held), 32'b0001);
        send(8'hF0);
        send(8'h23);
        ticks(5);
        check("released_i", 32'(bus.i), 32'd40);

        // Extended down arrow
        send(8'hE0);
        send(8'h72);
        ticks(3);
        check("extdown_j", 32'(bus.j), 32'd12);
        check("extdown_keys", 32'(bus.keys_held), 32'b0100);
        send(8'hE0);
        send(8'hF0);
        send(8'h72);
        check("extbreak_keys", 32'(bus.keys_held), 32'd0);
        send(8'hF0);
        send(8'h75);
        check("stray_break_keys", 32'(bus.keys_held), 32'd0);
        send(8'h23);   // decoder must be back in idle to take this as a make
        check("idle_after_stray", 32'(bus.keys_held), 32'b0001);
        send(8'hF0);
        send(8'h23);

        // Recentre then approach the right limit
        send(8'h29);
        check("centre0_i", 32'(bus.i), 32'd270);
        check("centre0_j", 32'(bus.j), 32'd190);
        send(8'h23);
        ticks(67);
        check("near_edge_i", 32'(bus.i), 32'd538);
        ticks(1);
`ifdef BLOCK_MOVER_WRAP_EN
        check("wrap_i", 32'(bus.i), 32'd0);
        ticks(1);
        check("wrap_next_i", 32'(bus.i), 32'd4);
        check("wrap_edge", 32'(bus.at_edge), 32'd0);
`else
        ticks(1);
        check("clamp_i", 32'(bus.i), 32'd540);
        check("clamp_edge", 32'(bus.at_edge), 32'd1);
`endif
        send(8'hF0);
        send(8'h23);
        ticks(1);
        check("edge_clear", 32'(bus.at_edge), 32'd0);

        // Both horizontal keys held cancel; break in the same cycle as a tick
        send(8'h29);
        send(8'h1C);
        send(8'h23);
        ticks(4);
        check("both_held_i", 32'(bus.i), 32'd270);
        send(8'hF0);
        cyc(1'b1, 8'h23, 1'b1);
        check("same_cycle_i", 32'(bus.i), 32'd270);
        check("same_cycle_keys", 32'(bus.keys_held), 32'b0010);
        ticks(1);
        check("left_after_i", 32'(bus.i), 32'd266);
        send(8'hF0);
        send(8'h1C);

        // Mode switch re-clamp
        bus.mode = 1'b1;
        do_reset();
        send(8'h23);
        send(8'h1B);
        ticks(125);
        send(8'hF0);
        send(8'h1B);
        ticks(50);
        check("mode1_i", 32'(bus.i), 32'd700);
        check("mode1_j", 32'(bus.j), 32'd500);
        send(8'hF0);
        send(8'h23);
        bus.mode = 1'b0;
        cyc(1'b0, 8'h00, 1'b0);
        check("reclamp_i", 32'(bus.i), 32'd540);
        check("reclamp_j", 32'(bus.j), 32'd380);
        send(8'h29);
        check("centre_after_i", 32'(bus.i), 32'd270);
        check("centre_after_j", 32'(bus.j), 32'd190);

        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
